// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 1-bpp framebuffer scan-out, 3-stage pipeline from timing counters to VGA DAC pins.
module vga_fb_scanout #(
   parameter int          H_VISIBLE      = 640,
   parameter int          V_VISIBLE      = 480,
   parameter int          H_TOTAL        = 800,
   parameter int          V_TOTAL        = 525,
   parameter int          WORDS_PER_LINE = 40,
   parameter int          ADDR_W         = 15,
   parameter logic [23:0] FG_RGB         = 24'hFFFFFF,
   parameter logic [23:0] BG_RGB         = 24'h000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        p_count,
   input  logic [9:0]        l_count,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              blank_n_in,
   input  logic              scan_en,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_rd_en,
   input  logic [15:0]       fb_rdata,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N
);
   localparam logic [9:0]        HV    = 10'(H_VISIBLE);
   localparam logic [9:0]        VV    = 10'(V_VISIBLE);
   localparam logic [9:0]        HT_M1 = 10'(H_TOTAL - 1);
   localparam logic [9:0]        VT_M1 = 10'(V_TOTAL - 1);
   localparam logic [ADDR_W-1:0] WPL   = ADDR_W'(WORDS_PER_LINE);

   logic [ADDR_W-1:0] line_base_q, line_base_d, addr_q, addr_d;
   logic              rd1_q, rd1_d, vis1_q, vis_d, hs1_q, vs1_q, bn1_q;
   logic [3:0]        bit1_q, bit2_q;
   logic              rdv2_q, vis2_q, hs2_q, vs2_q, bn2_q;
   logic [15:0]       word_hold_q, word_hold_d, word_cur;
   logic              pix;
   logic [23:0]       rgb_q, rgb_d;
   logic              hs3_q, vs3_q, bn3_q;

   always_comb begin
      vis_d       = blank_n_in & scan_en & (p_count < HV) & (l_count < VV);
      rd1_d       = vis_d & (p_count[3:0] == 4'd0);
      addr_d      = line_base_q + ADDR_W'(p_count[9:4]);
      // frame wrap wins over the per-line advance; blank lines hold the base
      line_base_d = (p_count != HT_M1) ? line_base_q :
                    (l_count == VT_M1) ? '0 :
                    (l_count < VV)     ? line_base_q + WPL : line_base_q;
      word_cur    = rdv2_q ? fb_rdata : word_hold_q;
      word_hold_d = rdv2_q ? fb_rdata : word_hold_q;
      pix         = word_cur[4'd15 - bit2_q];
      rgb_d       = !bn2_q ? 24'h0 :
                    vis2_q ? (pix ? FG_RGB : BG_RGB) :
                    (scan_en ? 24'h0 : BG_RGB);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_base_q <= '0;
         addr_q      <= '0;
         rd1_q       <= 1'b0;
         vis1_q      <= 1'b0;
         bit1_q      <= '0;
         hs1_q       <= 1'b0;
         vs1_q       <= 1'b0;
         bn1_q       <= 1'b0;
         rdv2_q      <= 1'b0;
         vis2_q      <= 1'b0;
         bit2_q      <= '0;
         hs2_q       <= 1'b0;
         vs2_q       <= 1'b0;
         bn2_q       <= 1'b0;
         word_hold_q <= '0;
         rgb_q       <= '0;
         hs3_q       <= 1'b1;
         vs3_q       <= 1'b1;
         bn3_q       <= 1'b0;
      end else begin
         line_base_q <= line_base_d;
         addr_q      <= addr_d;
         rd1_q       <= rd1_d;
         vis1_q      <= vis_d;
         bit1_q      <= p_count[3:0];
         hs1_q       <= hs_in;
         vs1_q       <= vs_in;
         bn1_q       <= blank_n_in;
         rdv2_q      <= rd1_q;
         vis2_q      <= vis1_q;
         bit2_q      <= bit1_q;
         hs2_q       <= hs1_q;
         vs2_q       <= vs1_q;
         bn2_q       <= bn1_q;
         word_hold_q <= word_hold_d;
         rgb_q       <= rgb_d;
         hs3_q       <= hs2_q;
         vs3_q       <= vs2_q;
         bn3_q       <= bn2_q;
      end
   end

   assign fb_addr     = addr_q;
   assign fb_rd_en    = rd1_q;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_HS      = hs3_q;
   assign VGA_VS      = vs3_q;
   assign VGA_BLANK_N = bn3_q;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: directed scan-out bench on a shrunken raster, scoreboard of pixel/sync outputs.
module tb_vga_fb_scanout;
   localparam int          HV = 64, VV = 6, HT = 100, VT = 10, WPL = 4, AW = 15;
   localparam int          HS0 = 80, HS1 = 90, VS0 = 7;
   localparam logic [23:0] FG = 24'hFFFFFF, BG = 24'h202020;

   logic          clk = 1'b0, rst = 1'b1;
   logic [9:0]    p_count = '0, l_count = '0;
   logic          hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b0, scan_en = 1'b1;
   logic [AW-1:0] fb_addr;
   logic          fb_rd_en;
   logic [15:0]   fb_rdata = '0;
   logic [7:0]    VGA_R, VGA_G, VGA_B;
   logic          VGA_HS, VGA_VS, VGA_BLANK_N;

   int            n_chk = 0, n_err = 0, reads = 0, m_lb = 0;
   logic [26:0]   q[$];
   bit            chk_fb = 0, exp_rd = 0;
   logic [AW-1:0] exp_addr = '0;

   vga_fb_scanout #(.H_VISIBLE(HV), .V_VISIBLE(VV), .H_TOTAL(HT), .V_TOTAL(VT),
      .WORDS_PER_LINE(WPL), .ADDR_W(AW), .FG_RGB(FG), .BG_RGB(BG)) dut (
      .clk(clk), .rst(rst), .p_count(p_count), .l_count(l_count), .hs_in(hs_in),
      .vs_in(vs_in), .blank_n_in(blank_n_in), .scan_en(scan_en), .fb_addr(fb_addr),
      .fb_rd_en(fb_rd_en), .fb_rdata(fb_rdata), .VGA_R(VGA_R), .VGA_G(VGA_G),
      .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N));

   always #5 clk = ~clk;

   function automatic logic [15:0] word(input logic [AW-1:0] a);
      return (a == '0) ? 16'h8001 : ({a[7:0], ~a[7:0]} ^ {1'b0, a});
   endfunction

   always @(posedge clk) if (fb_rd_en) fb_rdata <= word(fb_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset();
      check("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
      check("rst_hs", 32'(VGA_HS), 32'h1);
      check("rst_vs", 32'(VGA_VS), 32'h1);
      check("rst_blank_n", 32'(VGA_BLANK_N), 32'h0);
      check("rst_rd_en", 32'(fb_rd_en), 32'h0);
      check("rst_addr", 32'(fb_addr), 32'h0);
   endtask

   task automatic cycle(input int p, input int l, input bit en);
      logic vis, pix;
      logic [23:0] col;
      logic [AW-1:0] a;
      logic [15:0] w;
      @(negedge clk);
      if (q.size() == 3) check("pixel", {5'b0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, {5'b0, q.pop_front()});
      if (chk_fb) begin
         check("rd_en", 32'(fb_rd_en), 32'(exp_rd));
         if (exp_rd) check("addr", 32'(fb_addr), 32'(exp_addr));
      end
      reads += int'(fb_rd_en);
      p_count    = 10'(p);
      l_count    = 10'(l);
      scan_en    = en;
      hs_in      = !(p >= HS0 && p < HS1);
      vs_in      = !(l == VS0 || l == VS0 + 1);
      blank_n_in = (p < HV + 2) && (l < VV);
      vis        = blank_n_in && en && p < HV && l < VV;
      a          = AW'(m_lb + p / 16);
      w          = word(a);
      pix        = w[4'(15 - p % 16)];
      exp_rd     = vis && (p % 16 == 0);
      exp_addr   = a;
      chk_fb     = 1;
      col        = !blank_n_in ? 24'h0 : vis ? (pix ? FG : BG) : (en ? 24'h0 : BG);
      q.push_back({col, hs_in, vs_in, blank_n_in});
      if (p == HT - 1) m_lb = (l == VT - 1) ? 0 : (l < VV) ? m_lb + WPL : m_lb;
   endtask

   task automatic frame(input bit en);
      for (int l = 0; l < VT; l++)
         for (int p = 0; p < HT; p++) cycle(p, l, en);
   endtask

   initial begin
      @(negedge clk);
      chk_reset();
      rst = 1'b0;
      frame(1'b1);
      for (int l = 0; l < 4; l++)
         for (int p = 0; p < HT; p++)
            if (!(l == 3 && p > 30)) cycle(p, l, 1'b1);
      #2 rst = 1'b1;
      #1 chk_reset();
      q.delete();
      m_lb   = 0;
      chk_fb = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      reads = 0;
      frame(1'b1);
      check("reads_frame_on", 32'(reads), 32'(WPL * VV));
      reads = 0;
      frame(1'b0);
      check("reads_frame_off", 32'(reads), 32'h0);
      reads = 0;
      frame(1'b1);
      check("reads_frame_on2", 32'(reads), 32'(WPL * VV));
      for (int p = 0; p < 4; p++) cycle(p, 0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Monochrome 1-bpp framebuffer scan-out stage sitting directly downstream of the VGA timing generator.
- Consumes the generator's pixel/line counters and sync/blank strobes.
- Fetches 16-pixel words from a synchronous-read framebuffer RAM and expands each bit to a 24-bit foreground/background colour.
- Drives the VGA DAC pins with sync and blank delayed to stay pixel-aligned with the colour data.

Parameters:
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.
- H_TOTAL, 800, pixel clocks per line (p_count runs 0..H_TOTAL-1).
- V_TOTAL, 525, lines per frame (l_count runs 0..V_TOTAL-1).
- WORDS_PER_LINE, 40, 16-bit words per visible line (H_VISIBLE/16).
- ADDR_W, 15, framebuffer word-address width (19200 words).
- FG_RGB, 24'hFFFFFF, colour for bit=1, as {R,G,B}.
- BG_RGB, 24'h000000, colour for bit=0, and for all pixels when scan_en=0.

Ports:
- clk  in  1  pixel clock (25.175 MHz PLL output).
- rst  in  1  asynchronous reset, active-high.
- p_count  in  10  pixel counter from timing generator.
- l_count  in  10  line counter from timing generator.
- hs_in  in  1  horizontal sync, active-low.
- vs_in  in  1  vertical sync, active-low.
- blank_n_in  in  1  1 = visible pixel.
- scan_en  in  1  1 = fetch and display framebuffer; 0 = show BG_RGB, no reads.
- fb_addr  out  ADDR_W  framebuffer word address (registered).
- fb_rd_en  out  1  read strobe (registered).
- fb_rdata  in  16  RAM read data, valid exactly 1 cycle after the fb_addr/fb_rd_en cycle. Bit 15 = leftmost pixel.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  delayed hs_in, vs_in, blank_n_in.

Behaviour:
- Reset (async, rst=1) values:
  - fb_addr=0, fb_rd_en=0.
  - RGB=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - line_base=0, all pipeline registers 0; held word=0.
- Fixed 3-cycle pipeline. Inputs sampled at edge E appear on the VGA outputs after edge E+2, i.e. stable during the cycle after E+2.
  - Stage 1 (edge E):
    - vis = blank_n_in & scan_en & (p_count<H_VISIBLE) & (l_count<V_VISIBLE).
    - fb_rd_en <= vis & (p_count[3:0]==0).
    - fb_addr <= line_base + p_count[9:4], truncated to ADDR_W.
    - bit index, vis, hs/vs/blank_n all registered.
  - Stage 2 (edge E+1): registers rd_valid (stage-1 fb_rd_en), bit index, vis, syncs.
  - Stage 3 (edge E+2):
    - word_cur = rd_valid ? fb_rdata : word_hold.
    - If rd_valid, word_hold <= fb_rdata.
    - pix = word_cur[15 - bitidx].
    - {R,G,B} <= stage-2 vis ? (pix ? FG_RGB : BG_RGB) : (scan_en ? 24'h0 : BG_RGB), gated to 0 when the delayed blank_n is 0.
    - Syncs registered out.
- Colour is always 0 when the delayed blank_n_in=0, regardless of scan_en.
- line_base update, evaluated at p_count==H_TOTAL-1:
  - If l_count==V_TOTAL-1: line_base <= 0 (frame wrap).
  - Else if l_count<V_VISIBLE: line_base <= line_base + WORDS_PER_LINE.
  - Else: hold.
  - Frame wrap takes priority.
- Word fetch: exactly one read per 16 visible pixels, i.e. 40 per line and 19200 per frame. No reads during blanking or while scan_en=0.
- scan_en changes take effect at stage 1. The pipeline drains naturally; no output glitch beyond pixel granularity.
- Reset released mid-frame: line_base starts at 0, so the partial first frame is displayed offset. Correct from the first frame wrap onward; the bench must ignore that partial frame.
- Address arithmetic is unsigned modulo 2^ADDR_W.
- No handshake with the RAM: it must guarantee 1-cycle read latency.

Test Plan:
- Reset: assert rst mid-stream -> immediately RGB=0, HS=VS=1, BLANK_N=0, fb_rd_en=0; after release, outputs follow inputs with 3-cycle delay.
- Sync alignment: drive the full 800x525 counter sequence -> VGA_HS low exactly for p_count 656..751 delayed by 3 clocks; VGA_VS low for l_count 490..491 delayed by 3.
- Address sequence: RAM model word n = n -> line 0 reads addresses 0..39 at p_count 0,16,..,624 (fb_rd_en 1 cycle after). Line 1 starts at 40; line 479 ends at 19199; next frame restarts at 0. 19200 reads per frame.
- Pixel expansion: word 0 = 16'h8001, others 0 -> pixel (0,0) and (15,0) output FFFFFF, pixels (1..14,0) output 000000, at 3-cycle latency.
- Blank and disable: scan_en=0 with BG_RGB=24'h202020 -> no fb_rd_en, visible pixels 202020, blanked pixels 000000.
- Boundary: p_count 639->640 -> last pixel coloured, first blank pixel RGB=0. Frame wrap at (799,524) -> line_base=0 on the next cycle.
